// File: rtl/run_phase_arbiter_pkg.sv
// Shared types for the run-phase arbiter: phase encoding and a small
// modulo-index helper used by the round-robin search.
package run_phase_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        RUN   = 2'b10,
        STOP  = 2'b11
    } phase_e;

    // (base + off) mod n for off < n, without a divider.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/run_phase_arbiter_if.sv
// Bundle between requesting engines (master) and the arbiter (slave).
// Optional counters exist only when RUN_PHASE_ARBITER_RUN_COUNT_EN is defined.
//
// Handshake: there is no valid/ready pair. req is a level held by the
// requester; the arbiter samples it only in IDLE. grant (one-hot) acts as the
// acknowledge and stays stable from START through the last STOP cycle; done
// (with aborted) is a single-cycle completion strobe in the following IDLE
// cycle. Requesters may drop req any time after seeing their grant.
interface run_phase_arbiter_if
    import run_phase_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] run_len;
    logic                     abort;
    logic [PHASE_W-1:0]       state;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic                     done;
    logic                     aborted;
`ifdef RUN_PHASE_ARBITER_RUN_COUNT_EN
    logic [15:0]              run_count;
    logic [7:0]               abort_count;

    modport master (output req, run_len, abort,
                    input  state, grant, busy, done, aborted, run_count, abort_count);
    modport slave  (input  req, run_len, abort,
                    output state, grant, busy, done, aborted, run_count, abort_count);
`else
    modport master (output req, run_len, abort,
                    input  state, grant, busy, done, aborted);
    modport slave  (input  req, run_len, abort,
                    output state, grant, busy, done, aborted);
`endif
endinterface

// File: rtl/run_phase_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping. The pointer register lives in the parent.
module rr_arbiter
    import run_phase_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic found;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[wrap_idx(int'(ptr), i, NUM_REQ)]) begin
                found = 1'b1;
                grant[wrap_idx(int'(ptr), i, NUM_REQ)] = 1'b1;
                idx = PTR_W'(wrap_idx(int'(ptr), i, NUM_REQ));
            end
        end
    end
endmodule

// File: rtl/run_phase_arbiter.sv
// Round-robin owner of the shared IDLE->START->RUN->STOP sequence.
// Optional feature macro: RUN_PHASE_ARBITER_RUN_COUNT_EN adds run_count and
// abort_count completion counters.
module run_phase_arbiter
    import run_phase_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LEN_W       = 8,
    parameter int STOP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    run_phase_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SC_W  = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

    phase_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   win_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   run_cnt_q;
    logic [SC_W-1:0]    stop_cnt_q;
    logic               abort_flag_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic [LEN_W-1:0]   sel_len;
    logic [PTR_W-1:0]   ptr_next;

`ifdef RUN_PHASE_ARBITER_RUN_COUNT_EN
    logic [15:0] run_count_q;
    logic [7:0]  abort_count_q;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Candidate winner's length and the post-run pointer value.
    always_comb begin
        sel_len  = bus.run_len[int'(arb_idx)*LEN_W +: LEN_W];
        ptr_next = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + PTR_W'(1);
    end

    // Phase FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            ptr_q        <= '0;
            win_q        <= '0;
            len_q        <= '0;
            run_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            abort_flag_q <= 1'b0;
`ifdef RUN_PHASE_ARBITER_RUN_COUNT_EN
            run_count_q   <= '0;
            abort_count_q <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort outranks a fresh request
                    if (!bus.abort && (|bus.req)) begin
                        state_q      <= START;
                        grant_q      <= arb_grant;
                        win_q        <= arb_idx;
                        len_q        <= sel_len;
                        busy_q       <= 1'b1;
                        abort_flag_q <= 1'b0;
                    end
                end
                START: begin
                    run_cnt_q <= (len_q == '0) ? LEN_W'(1) : len_q;
                    if (bus.abort) begin
                        state_q      <= STOP;
                        stop_cnt_q   <= SC_W'(STOP_CYCLES-1);
                        abort_flag_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q      <= STOP;
                        stop_cnt_q   <= SC_W'(STOP_CYCLES-1);
                        abort_flag_q <= 1'b1;
                    end else if (run_cnt_q == LEN_W'(1)) begin
                        state_q    <= STOP;
                        stop_cnt_q <= SC_W'(STOP_CYCLES-1);
                    end else begin
                        run_cnt_q <= run_cnt_q - LEN_W'(1);
                    end
                end
                STOP: begin
                    if (stop_cnt_q == '0) begin
                        state_q      <= IDLE;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        aborted_q    <= abort_flag_q;
                        ptr_q        <= ptr_next;
                        abort_flag_q <= 1'b0;
`ifdef RUN_PHASE_ARBITER_RUN_COUNT_EN
                        run_count_q <= run_count_q + 16'd1;
                        if (abort_flag_q) abort_count_q <= abort_count_q + 8'd1;
`endif
                    end else begin
                        stop_cnt_q <= stop_cnt_q - SC_W'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    grant_q      <= '0;
                    busy_q       <= 1'b0;
                    abort_flag_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
`ifdef RUN_PHASE_ARBITER_RUN_COUNT_EN
    assign bus.run_count   = run_count_q;
    assign bus.abort_count = abort_count_q;
`endif
endmodule
